// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter
// Shares the single write port (we3/wa3/wd3) of the 16 x 128-bit vector
// register bank between the vector ALU and the vector load unit. It also
// keeps a per-register busy scoreboard so the issue stage can detect
// read-after-write hazards.
//
// Handshake (both requesters): a transfer happens in a cycle where valid and
// ready are both high and rst is low. ready is combinational from the two
// valids and the round-robin pointer, and at most one ready is high at a
// time. A requester holds valid/addr/data stable until it is granted.
//
// Optional build macro VREG_WB_STATS_EN adds the `conflicts` counter and the
// `orphan_wr` pulse output.
module vreg_wb_arbiter #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_data,
    output logic            ld_ready,
    input  logic            iss_set,
    input  logic [AW-1:0]   iss_addr,
    input  logic [AW-1:0]   chk_ra1,
    input  logic [AW-1:0]   chk_ra2,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3
`ifdef VREG_WB_STATS_EN
    ,
    output logic [15:0]     conflicts,
    output logic            orphan_wr
`endif
);

    // Round-robin pointer: which requester was granted most recently.
    localparam logic [0:0] LAST_ALU = 1'b0;
    localparam logic [0:0] LAST_LD  = 1'b1;

    logic [0:0]    last_q, last_d;
    logic          alu_xfer, ld_xfer;
    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic [NREG-1:0] busy_q, busy_d;

    // Grant: a lone requester always wins; on a conflict the requester not
    // granted last wins. No transfer counts while rst is high.
    always_comb begin
        alu_ready = alu_valid & (~ld_valid | (last_q == LAST_LD));
        ld_ready  = ld_valid  & (~alu_valid | (last_q == LAST_ALU));
        alu_xfer  = alu_ready & ~rst;
        ld_xfer   = ld_ready & ~rst;
        last_d    = last_q;
        if (alu_xfer) begin
            last_d = LAST_ALU;
        end else if (ld_xfer) begin
            last_d = LAST_LD;
        end
    end

    // Output-stage next state: load the granted address/data, else hold.
    always_comb begin
        we3_d = alu_xfer | ld_xfer;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (alu_xfer) begin
            wa3_d = alu_addr;
            wd3_d = alu_data;
        end else if (ld_xfer) begin
            wa3_d = ld_addr;
            wd3_d = ld_data;
        end
    end

    // Scoreboard next state: commit clears first, so a reservation of the
    // same register in the same cycle overrides the commit.
    always_comb begin
        busy_d = busy_q;
        if (we3_q) begin
            busy_d[wa3_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // State registers; reset drops any write pending in the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= LAST_LD;
            we3_q  <= 1'b0;
            wa3_q  <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            last_q <= last_d;
            we3_q  <= we3_d;
            wa3_q  <= wa3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    // Outputs are forced quiet while rst is high so a pending write never
    // reaches the bank during reset.
    always_comb begin
        we3    = we3_q & ~rst;
        wa3    = rst ? '0 : wa3_q;
        wd3    = rst ? '0 : wd3_q;
        busy   = rst ? '0 : busy_q;
        hazard = ~rst & (busy_q[chk_ra1] | busy_q[chk_ra2]);
    end

`ifdef VREG_WB_STATS_EN
    logic [15:0] conflicts_q, conflicts_d;

    // Saturating count of cycles where both requesters are valid.
    always_comb begin
        conflicts_d = conflicts_q;
        if (alu_valid && ld_valid && (conflicts_q != 16'hFFFF)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflicts_q <= '0;
        end else begin
            conflicts_q <= conflicts_d;
        end
    end

    // A commit to a register nobody reserved is flagged for the cycle it writes.
    always_comb begin
        conflicts = conflicts_q;
        orphan_wr = we3 & ~busy_q[wa3_q];
    end
`endif

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Testbench for vreg_wb_arbiter: table-driven vectors, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_vreg_wb_arbiter;

    logic         clk;
    logic         rst;
    logic         alu_valid;
    logic [3:0]   alu_addr;
    logic [127:0] alu_data;
    logic         alu_ready;
    logic         ld_valid;
    logic [3:0]   ld_addr;
    logic [127:0] ld_data;
    logic         ld_ready;
    logic         iss_set;
    logic [3:0]   iss_addr;
    logic [3:0]   chk_ra1;
    logic [3:0]   chk_ra2;
    logic         hazard;
    logic [15:0]  busy;
    logic         we3;
    logic [3:0]   wa3;
    logic [127:0] wd3;
`ifdef VREG_WB_STATS_EN
    logic [15:0]  conflicts;
    logic         orphan_wr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vreg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_set(iss_set), .iss_addr(iss_addr), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
        .hazard(hazard), .busy(busy), .we3(we3), .wa3(wa3), .wd3(wd3)
`ifdef VREG_WB_STATS_EN
        , .conflicts(conflicts), .orphan_wr(orphan_wr)
`endif
    );

    // Clock and initial reset level.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         av;
        logic [3:0]   aa;
        logic         lv;
        logic [3:0]   la;
        logic         iss;
        logic [3:0]   ia;
        logic [3:0]   r1;
        logic [3:0]   r2;
        logic         ear;
        logic         elr;
        logic         ewe;
        logic [3:0]   ewa;
        logic [127:0] ewd;
        logic         ehz;
    } vec_t;

    vec_t vt[10];

    function automatic logic [127:0] adat(input logic [3:0] a);
        return {32{a}};
    endfunction

    function automatic logic [127:0] ldat(input logic [3:0] a);
        return ~{32{a}};
    endfunction

    function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic lv,
                                input logic [3:0] la, input logic iss, input logic [3:0] ia,
                                input logic [3:0] r1, input logic [3:0] r2, input logic ear,
                                input logic elr, input logic ewe, input logic [3:0] ewa,
                                input logic [127:0] ewd, input logic ehz);
        vec_t v;
        v.av = av; v.aa = aa; v.lv = lv; v.la = la; v.iss = iss; v.ia = ia;
        v.r1 = r1; v.r2 = r2; v.ear = ear; v.elr = elr; v.ewe = ewe;
        v.ewa = ewa; v.ewd = ewd; v.ehz = ehz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        iss_set = 1'b0; iss_addr = '0; chk_ra1 = '0; chk_ra2 = '0;
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [127:0] ad,
                         input logic lv, input logic [3:0] la, input logic [127:0] ldd);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid = lv; ld_addr = la; ld_data = ldd;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_we3"}, 128'(we3), 128'(0));
        chk({nm, "_wa3"}, 128'(wa3), 128'(0));
        chk({nm, "_wd3"}, wd3, 128'(0));
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_hazard"}, 128'(hazard), 128'(0));
    endtask

    // Behavioural model state for the randomized run.
    bit           m_busy[16];
    int           m_last;   // 0: ALU granted most recently, 1: load unit
    bit           m_we;
    logic [3:0]   m_wa;
    logic [127:0] m_wd;
    int           m_conf;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last = 1;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        m_conf = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ---------------- table-driven vectors ----------------
        //        av aa    lv la    iss ia    r1    r2    ar lr we wa    wd           hz
        vt[0] = mk(1, 4'd1, 1, 4'd2, 1, 4'd3, 4'd3, 4'd3, 1, 0, 0, 4'd0, 128'(0),    0);
        vt[1] = mk(1, 4'd4, 1, 4'd2, 0, 4'd0, 4'd3, 4'd0, 0, 1, 1, 4'd1, adat(4'd1), 1);
        vt[2] = mk(1, 4'd4, 0, 4'd0, 0, 4'd0, 4'd0, 4'd1, 1, 0, 1, 4'd2, ldat(4'd2), 0);
        vt[3] = mk(0, 4'd0, 1, 4'd3, 0, 4'd0, 4'd3, 4'd3, 0, 1, 1, 4'd4, adat(4'd4), 1);
        vt[4] = mk(0, 4'd0, 0, 4'd0, 1, 4'd3, 4'd3, 4'd3, 0, 0, 1, 4'd3, ldat(4'd3), 1);
        vt[5] = mk(0, 4'd0, 0, 4'd0, 0, 4'd0, 4'd3, 4'd3, 0, 0, 0, 4'd3, ldat(4'd3), 1);
        vt[6] = mk(1, 4'd3, 0, 4'd0, 0, 4'd0, 4'd3, 4'd5, 1, 0, 0, 4'd3, ldat(4'd3), 1);
        vt[7] = mk(0, 4'd0, 0, 4'd0, 0, 4'd0, 4'd3, 4'd3, 0, 0, 1, 4'd3, adat(4'd3), 1);
        vt[8] = mk(0, 4'd0, 0, 4'd0, 0, 4'd0, 4'd3, 4'd3, 0, 0, 0, 4'd3, adat(4'd3), 0);
        vt[9] = mk(1, 4'd7, 1, 4'd8, 0, 4'd0, 4'd7, 4'd8, 0, 1, 0, 4'd3, adat(4'd3), 0);

        do_reset();
        chk_quiet("tbl_reset");
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].av, vt[i].aa, adat(vt[i].aa), vt[i].lv, vt[i].la, ldat(vt[i].la));
            iss_set = vt[i].iss; iss_addr = vt[i].ia;
            chk_ra1 = vt[i].r1; chk_ra2 = vt[i].r2;
            #1;
            chk($sformatf("tbl%0d_alu_ready", i), 128'(alu_ready), 128'(vt[i].ear));
            chk($sformatf("tbl%0d_ld_ready", i), 128'(ld_ready), 128'(vt[i].elr));
            chk($sformatf("tbl%0d_we3", i), 128'(we3), 128'(vt[i].ewe));
            chk($sformatf("tbl%0d_wa3", i), 128'(wa3), 128'(vt[i].ewa));
            chk($sformatf("tbl%0d_wd3", i), wd3, vt[i].ewd);
            chk($sformatf("tbl%0d_hazard", i), 128'(hazard), 128'(vt[i].ehz));
            tick();
        end

        // ---------------- reset and single ALU write ----------------
        do_reset();
        chk_quiet("single_reset");
        drive(1, 4'h0, 128'hFF, 0, 4'h0, 128'h0);
        #1;
        chk("single_alu_ready", 128'(alu_ready), 128'(1));
        tick();
        idle_inputs();
        #1;
        chk("single_we3", 128'(we3), 128'(1));
        chk("single_wa3", 128'(wa3), 128'(0));
        chk("single_wd3", wd3, 128'hFF);
        tick();
        chk("single_we3_off", 128'(we3), 128'(0));

        // ---------------- conflict round-robin ----------------
        do_reset();
        drive(1, 4'h1, 128'h11, 1, 4'h2, 128'h22);
        #1;
        chk("rr0_alu_ready", 128'(alu_ready), 128'(1));
        chk("rr0_ld_ready", 128'(ld_ready), 128'(0));
        tick();
        chk("rr1_alu_ready", 128'(alu_ready), 128'(0));
        chk("rr1_ld_ready", 128'(ld_ready), 128'(1));
        chk("rr1_we3", 128'(we3), 128'(1));
        chk("rr1_wa3", 128'(wa3), 128'(1));
        tick();
        chk("rr2_alu_ready", 128'(alu_ready), 128'(1));
        chk("rr2_ld_ready", 128'(ld_ready), 128'(0));
        chk("rr2_we3", 128'(we3), 128'(1));
        chk("rr2_wa3", 128'(wa3), 128'(2));
        chk("rr2_wd3", wd3, 128'h22);
        tick();
        idle_inputs();
        #1;
        chk("rr3_we3", 128'(we3), 128'(1));
        chk("rr3_wa3", 128'(wa3), 128'(1));
        chk("rr3_wd3", wd3, 128'h11);
        tick();
        chk("rr4_we3", 128'(we3), 128'(0));

        // ---------------- scoreboard hazard ----------------
        do_reset();
        iss_set = 1'b1; iss_addr = 4'hF; chk_ra1 = 4'hF; chk_ra2 = 4'h0;
        #1;
        chk("hz_before_set", 128'(hazard), 128'(0));
        tick();
        iss_set = 1'b0;
        #1;
        chk("hz_after_set", 128'(hazard), 128'(1));
        chk("hz_busy_set", 128'(busy), 128'(16'h8000));
        drive(0, 4'h0, 128'h0, 1, 4'hF, 128'hFF000000000000FF);
        #1;
        chk("hz_ld_ready", 128'(ld_ready), 128'(1));
        tick();
        drive(0, 4'h0, 128'h0, 0, 4'h0, 128'h0);
        #1;
        chk("hz_we3", 128'(we3), 128'(1));
        chk("hz_wa3", 128'(wa3), 128'(15));
        chk("hz_wd3", wd3, 128'hFF000000000000FF);
        chk("hz_during_commit", 128'(hazard), 128'(1));
        tick();
        chk("hz_busy_clear", 128'(busy), 128'(0));
        chk("hz_after_commit", 128'(hazard), 128'(0));

        // ---------------- reset mid-operation ----------------
        do_reset();
        iss_set = 1'b1; iss_addr = 4'h9;
        drive(0, 4'h0, 128'h0, 1, 4'h5, 128'h55);
        #1;
        chk("rmid_ld_ready", 128'(ld_ready), 128'(1));
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rmid_we3_in_rst", 128'(we3), 128'(0));
        chk("rmid_busy_in_rst", 128'(busy), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        chk_quiet("rmid_after");
        tick();
        chk("rmid_we3_later", 128'(we3), 128'(0));

`ifdef VREG_WB_STATS_EN
        // ---------------- statistics ----------------
        do_reset();
        chk("st_conf_reset", 128'(conflicts), 128'(0));
        chk("st_orph_reset", 128'(orphan_wr), 128'(0));
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'h1, 128'h1, 1, 4'h2, 128'h2);
            tick();
        end
        idle_inputs();
        #1;
        chk("st_conf_5", 128'(conflicts), 128'(5));
        do_reset();
        drive(1, 4'h6, 128'h6, 0, 4'h0, 128'h0);
        tick();
        idle_inputs();
        #1;
        chk("st_orph_pulse", 128'(orphan_wr), 128'(1));
        tick();
        chk("st_orph_done", 128'(orphan_wr), 128'(0));
        iss_set = 1'b1; iss_addr = 4'h7;
        tick();
        iss_set = 1'b0;
        drive(1, 4'h7, 128'h7, 0, 4'h0, 128'h0);
        tick();
        idle_inputs();
        #1;
        chk("st_orph_busy_we3", 128'(we3), 128'(1));
        chk("st_orph_busy", 128'(orphan_wr), 128'(0));
`endif

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        begin
            bit           a_v, l_v, iss, ga, gl;
            logic [3:0]   a_a, l_a, ia, r1, r2;
            logic [127:0] a_d, l_d;
            logic [15:0]  bv;
            a_v = 1'b0; l_v = 1'b0;
            a_a = '0; l_a = '0; a_d = '0; l_d = '0;
            for (int c = 0; c < 400; c++) begin
                // New requests only when the previous one has been taken.
                if (!a_v && $urandom_range(0, 2) != 0) begin
                    a_v = 1'b1; a_a = 4'($urandom_range(0, 15));
                    a_d = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!l_v && $urandom_range(0, 2) != 0) begin
                    l_v = 1'b1; l_a = 4'($urandom_range(0, 15));
                    l_d = {$urandom, $urandom, $urandom, $urandom};
                end
                iss = ($urandom_range(0, 3) == 0);
                ia = 4'($urandom_range(0, 15));
                r1 = 4'($urandom_range(0, 15));
                r2 = 4'($urandom_range(0, 15));
                drive(a_v, a_a, a_d, l_v, l_a, l_d);
                iss_set = iss; iss_addr = ia; chk_ra1 = r1; chk_ra2 = r2;
                #1;

                // Who wins: a lone requester, or on a conflict the one not granted last.
                if (a_v && l_v) begin
                    ga = (m_last == 1);
                    gl = (m_last == 0);
                end else begin
                    ga = a_v;
                    gl = l_v;
                end
                for (int i = 0; i < 16; i++) bv[i] = m_busy[i];

                chk($sformatf("rnd%0d_alu_ready", c), 128'(alu_ready), 128'(ga));
                chk($sformatf("rnd%0d_ld_ready", c), 128'(ld_ready), 128'(gl));
                chk($sformatf("rnd%0d_we3", c), 128'(we3), 128'(m_we));
                chk($sformatf("rnd%0d_wa3", c), 128'(wa3), 128'(m_wa));
                chk($sformatf("rnd%0d_wd3", c), wd3, m_wd);
                chk($sformatf("rnd%0d_busy", c), 128'(busy), 128'(bv));
                chk($sformatf("rnd%0d_hazard", c), 128'(hazard), 128'(m_busy[r1] | m_busy[r2]));
`ifdef VREG_WB_STATS_EN
                chk($sformatf("rnd%0d_orphan", c), 128'(orphan_wr), 128'(m_we && !m_busy[m_wa]));
                chk($sformatf("rnd%0d_conflicts", c), 128'(conflicts), 128'(m_conf));
                if (a_v && l_v && m_conf < 65535) m_conf++;
`endif
                // Edge: commit clears, a new reservation sets (set wins on same register).
                if (m_we) m_busy[m_wa] = 1'b0;
                if (iss) m_busy[ia] = 1'b1;
                m_we = ga || gl;
                if (ga) begin
                    m_wa = a_a; m_wd = a_d; m_last = 0; a_v = 1'b0;
                end else if (gl) begin
                    m_wa = l_a; m_wd = l_d; m_last = 1; l_v = 1'b0;
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vreg_wb_arbiter.md
Name: vreg_wb_arbiter

Overview:
- Shares the single write port (we3/wa3/wd3) of the 16 x 128-bit vector register bank between two writeback sources: the vector ALU and the vector load unit.
- Keeps a per-register busy scoreboard so the issue stage can stall on read-after-write hazards against ra1/ra2.
- Sits between the execute/memory stages and Reg_bank; its we3/wa3/wd3 outputs connect directly to Reg_bank.

Parameters:
- NREG, 16, number of vector registers.
- AW, 4, register address width (log2 NREG).
- DW, 128, vector register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU has a result to write back.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- ld_valid  in  1  load unit has data to write back.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load data.
- ld_ready  out  1  load request granted this cycle.
- iss_set  in  1  issue stage reserves a destination register.
- iss_addr  in  AW  register being reserved.
- chk_ra1  in  AW  source register 1 of the instruction in issue.
- chk_ra2  in  AW  source register 2 of the instruction in issue.
- hazard  out  1  either source register is busy.
- busy  out  NREG  scoreboard bit vector.
- we3  out  1  register bank write enable.
- wa3  out  AW  register bank write address.
- wd3  out  DW  register bank write data.

Behaviour:
Handshake and arbitration
- Handshake is valid/ready. A transfer occurs in cycle N when valid and ready are both high in N.
- ready is combinational from the valid inputs and the round-robin pointer. At most one ready is high per cycle.
- Only one requester valid: that requester is granted.
- Both valid: grant the requester not granted last. The `last` pointer updates only on a grant.
- Reset sets last = LD, so the ALU wins the first conflict.
- Requesters hold valid, addr and data stable until granted.

Write port
- Output register stage: a grant in cycle N drives we3=1 with wa3/wd3 = granted addr/data in cycle N+1.
- No grant in N: we3=0 in N+1. wa3/wd3 hold their previous values.
- Throughput is one write per cycle; there are no bubbles between back-to-back grants.

Scoreboard
- busy[iss_addr] is set on the edge after iss_set=1.
- busy[wa3] is cleared on the edge ending a cycle with we3=1 (commit).
- Set and clear to the same address in the same cycle: set wins (a new reservation overrides the commit).
- Set and clear to different addresses in the same cycle: both take effect.
- A commit to a non-busy register is legal: the write goes through and busy is unchanged.
- hazard = busy[chk_ra1] | busy[chk_ra2], combinational from registered busy. hazard therefore drops the cycle after the commit edge, which matches the bank's write-on-edge timing.

Reset
- rst is synchronous and active-high, and overrides all other activity, including a pending output-stage write.
- Outputs during and after reset: we3=0, wa3=0, wd3=0, busy=0, hazard=0.
- alu_ready/ld_ready follow the valid inputs combinationally, but no transfer is counted while rst=1.
- A write sitting in the output stage when rst asserts is dropped; we3 stays 0.

Optional Feature:
- Macro: VREG_WB_STATS_EN.
- Defined:
  - Adds output `conflicts`, 16 bits, a saturating count (stops at 16'hFFFF) of cycles with alu_valid & ld_valid both high.
  - Adds output `orphan_wr`, 1 bit, pulsing high for one cycle whenever we3=1 targets a non-busy register.
  - Both reset to 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset and single ALU write: rst 2 cycles, then alu_valid=1, addr=4'h0, data=128'hFF -> alu_ready=1 in the same cycle; next cycle we3=1, wa3=0, wd3=128'hFF; the cycle after, we3=0.
- Conflict round-robin: alu (4'h1, 128'h11) and ld (4'h2, 128'h22) held valid for 3 cycles -> grants ALU, LD, ALU; we3 writes 1, 2, 1 on consecutive cycles.
- Scoreboard hazard: iss_set on 4'hF, chk_ra1=4'hF -> hazard=1 next cycle; ld write to 4'hF of 128'hFF000000000000FF -> we3 one cycle after grant, busy[15]=0 and hazard=0 the following cycle.
- Simultaneous set/clear: commit to 4'h3 in the same cycle as iss_set to 4'h3 -> busy[3] stays 1.
- Reset mid-operation: grant ld (4'h5) then assert rst the next cycle -> we3 never asserts, busy=0.
- With VREG_WB_STATS_EN: 5 conflict cycles -> conflicts=5; a write to a non-busy register -> orphan_wr=1 for exactly one cycle.
